maclaurin_trig_unit: RTL
========================

Name: maclaurin_trig_unit

Overview:
- Parametrised successor to the fixed sin-only Maclaurin calculator: evaluates sin(x) or cos(x) through a run-time-selectable series with configurable width and term count.
- Single shared multiplier; FSM and datapath in one module with explicit start/busy/done handshake.
- Sits in the math cluster beside the existing sin top level.
- Intended as its drop-in replacement when instantiated with mode tied to 0.

Parameters:
XW, 16, input width; xBus is signed Q2.(XW-2) radians
RW, 18, output width; rBus is signed Q2.(RW-2)
TERMS, 8, number of series terms summed (legal range 2..12)
CW, 18, reciprocal-coefficient width, unsigned Q0.CW

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  request; sampled only when busy=0
mode  input  1  0=sin, 1=cos; sampled together with start
xBus  input  XW  operand; sampled together with start
rBus  output  RW  result; holds last value until next done
done  output  1  one-cycle pulse when rBus is updated
busy  output  1  high from the cycle after start acceptance up to and including the done cycle
sat  output  1  final sum saturated; valid with done, held with rBus

Behaviour:
- Reset (async, rst=1): state=IDLE; rBus=0, done=0, busy=0, sat=0; all internal registers cleared. Reset mid-computation aborts the computation and produces no done.
- Internal format: signed Q2.(IW-2) with IW=RW+4.
  - Operands are sign-extended or shifted into IW.
  - Every product is truncated by arithmetic right shift (floor).
- Coefficient ROM, entries k=1..TERMS-1, built by constant function at elaboration:
  - d = (2k)(2k+1) for sin, or (2k-1)(2k) for cos.
  - Entry = (2^CW + d/2) / d, integer division.
- FSM states:
  - IDLE: start=1 → LOAD; latch x and mode; busy rises next cycle. Otherwise stay.
  - LOAD: X2 = x*x. For sin, T=x. For cos, T=1.0. S=T. k=1 → MULA.
  - MULA: P = T*X2 → MULB.
  - MULB: T = -(P*coef[k]). S = S+T.
    - If k=TERMS-1 → FIN.
    - Else k=k+1 → MULA.
  - FIN: saturate S to RW range, drop the 2 guard LSBs, write rBus and sat; done=1 for this cycle only → IDLE.
- Latency: start sampled at edge 0; done is high in cycle 2*TERMS (16 for TERMS=8).
- Back-to-back operation: start is accepted in the cycle following FIN, since state is IDLE then.
- Boundary conditions:
  - start while busy=1: ignored, with no side effects.
  - mode or xBus changing during busy: no effect.
  - start asserted together with rst: rst wins.
  - |x| > pi/2: computed anyway with no clamp; accuracy is unspecified but sat is exact.
  - Saturation bounds: +(2^(RW-1)-1) and -2^(RW-1).
- Accuracy for |x| ≤ pi/2 with defaults: within ±4 LSB of the ideal value.

Optional Feature:
- Macro MACLAURIN_ROUND_EN.
- When defined:
  - Every product truncation and the final guard-bit drop use round-half-up: add 1 at the bit below the LSB before shifting.
  - Rounding may itself cause saturation, and sat reports it.
  - Accuracy bound tightens to ±2 LSB.
- When undefined: floor truncation as above.
- Latency and handshake are identical in both builds.

Test Plan:
- Defaults, mode=0, xBus=0 → done at cycle 16 exactly; rBus=0, sat=0, busy high during cycles 1–16.
- mode=0, xBus=25736 (pi/2) → rBus = 65536±4; mode=0, xBus=-25736 → rBus = -65536±4.
- mode=1, xBus=0 → rBus=65536 exactly. mode=1, xBus=25736 → rBus = 0±4.
- start pulsed again at cycles 3 and 10 with different xBus → single done at cycle 16, carrying the first operand's result. Then start in the cycle after done is accepted → second done 16 cycles later.
- rst pulsed at cycle 7 of a computation → outputs 0 immediately; no done; next start behaves normally.
- TERMS=4 instance, mode=1, xBus=0x7FFF (~2.0) → done at cycle 8. Expected value is cos(2) truncated-series ≈ -0.4222 → rBus = -27670±8, sat=0. Rerun the same vectors with MACLAURIN_ROUND_EN defined and check the ±2 LSB bounds.

Source files
------------

// File: rtl/maclaurin_trig_unit.sv
// Iterative sin/cos evaluator: Maclaurin series summed term by term through one shared multiplier.
// Build macro MACLAURIN_ROUND_EN selects round-half-up truncation instead of floor.
module maclaurin_trig_unit #(
    parameter int XW    = 16,
    parameter int RW    = 18,
    parameter int TERMS = 8,
    parameter int CW    = 18
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          mode,
    input  logic [XW-1:0] xBus,
    output logic [RW-1:0] rBus,
    output logic          done,
    output logic          busy,
    output logic          sat
);
    localparam int IW = RW + 4;
    localparam int FB = IW - 2;
    localparam int GW = IW - RW;
    // Four extra integer bits: x*x and the first cos term reach 4.0 and 2.0 near |x| = 2.
    localparam int AW = IW + 4;
    localparam int PW = 2 * AW;
    localparam int KW = $clog2(TERMS);

`ifdef MACLAURIN_ROUND_EN
    localparam logic ROUND_EN = 1'b1;
`else
    localparam logic ROUND_EN = 1'b0;
`endif

    localparam logic signed [PW-1:0] RND_Q = PW'(ROUND_EN) << (FB - 1);
    localparam logic signed [PW-1:0] RND_C = PW'(ROUND_EN) << (CW - 1);
    localparam logic signed [AW-1:0] RND_G = AW'(ROUND_EN) << (GW - 1);
    localparam logic signed [AW-1:0] ONE   = AW'(1) << FB;
    localparam logic signed [AW-1:0] R_MAX = (AW'(1) << (RW - 1)) - AW'(1);
    localparam logic signed [AW-1:0] R_MIN = -(AW'(1) << (RW - 1));

    function automatic logic [CW-1:0] coef_calc(input int k, input logic cos_sel);
        longint d;
        if (k < 1 || k >= TERMS) return '0;
        d = cos_sel ? longint'((2 * k - 1) * (2 * k)) : longint'((2 * k) * (2 * k + 1));
        return CW'(((longint'(1) << CW) + d / 2) / d);
    endfunction

    logic [CW-1:0] w_coef_rom [2][2**KW];
    for (genvar g = 0; g < 2**KW; g++) begin : g_rom
        assign w_coef_rom[0][g] = coef_calc(g, 1'b0);
        assign w_coef_rom[1][g] = coef_calc(g, 1'b1);
    end

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_MULA, S_MULB, S_FIN} state_t;

    state_t               r_state, w_state_next;
    logic        [KW-1:0] r_k;
    logic        [XW-1:0] r_x;
    logic                 r_mode;
    logic signed [AW-1:0] r_x2, r_t, r_p, r_s;
    logic        [RW-1:0] r_rbus;
    logic                 r_sat;

    logic                 w_last;
    logic        [CW-1:0] w_coef;
    logic signed [AW-1:0] w_x_ext, w_mul_a, w_mul_b, w_prod_q, w_prod_c;
    logic signed [AW-1:0] w_t_new, w_s_new, w_s_drop;
    logic signed [PW-1:0] w_prod;
    logic        [RW-1:0] w_rbus_next;
    logic                 w_sat_next;

    assign w_last  = (r_k == KW'(TERMS - 1));
    assign w_coef  = w_coef_rom[r_mode][r_k];
    assign w_x_ext = AW'($signed(r_x)) <<< (IW - XW);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_next;
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_next = r_state;
        busy         = 1'b1;
        done         = 1'b0;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) w_state_next = S_LOAD;
            end
            S_LOAD:  w_state_next = S_MULA;
            S_MULA:  w_state_next = S_MULB;
            S_MULB:  w_state_next = w_last ? S_FIN : S_MULA;
            S_FIN: begin
                done         = 1'b1;
                w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_mul_a = '0;
        w_mul_b = '0;
        case (r_state)
            S_LOAD: begin w_mul_a = w_x_ext; w_mul_b = w_x_ext;     end
            S_MULA: begin w_mul_a = r_t;     w_mul_b = r_x2;        end
            S_MULB: begin w_mul_a = r_p;     w_mul_b = AW'(w_coef); end
            default: ;
        endcase
    end

    assign w_prod   = PW'(w_mul_a) * PW'(w_mul_b);
    assign w_prod_q = AW'((w_prod + RND_Q) >>> FB);
    assign w_prod_c = AW'((w_prod + RND_C) >>> CW);
    assign w_t_new  = -w_prod_c;
    assign w_s_new  = r_s + w_t_new;
    assign w_s_drop = AW'((w_s_new + RND_G) >>> GW);

    // Result is formed from the final sum on the last MULB edge so it is on rBus while done is high.
    always_comb begin
        w_rbus_next = w_s_drop[RW-1:0];
        w_sat_next  = 1'b0;
        if (w_s_drop > R_MAX) begin
            w_rbus_next = R_MAX[RW-1:0];
            w_sat_next  = 1'b1;
        end else if (w_s_drop < R_MIN) begin
            w_rbus_next = R_MIN[RW-1:0];
            w_sat_next  = 1'b1;
        end
    end

    // NOTE: datapath registers are reset too, so an aborted run leaves no stale operand or result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_k    <= '0;
            r_x    <= '0;
            r_mode <= 1'b0;
            r_x2   <= '0;
            r_t    <= '0;
            r_p    <= '0;
            r_s    <= '0;
            r_rbus <= '0;
            r_sat  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (start) begin
                    r_x    <= xBus;
                    r_mode <= mode;
                end
                S_LOAD: begin
                    r_x2 <= w_prod_q;
                    r_t  <= r_mode ? ONE : w_x_ext;
                    r_s  <= r_mode ? ONE : w_x_ext;
                    r_k  <= KW'(1);
                end
                S_MULA: r_p <= w_prod_q;
                S_MULB: begin
                    r_t <= w_t_new;
                    r_s <= w_s_new;
                    r_k <= r_k + KW'(1);
                    if (w_last) begin
                        r_rbus <= w_rbus_next;
                        r_sat  <= w_sat_next;
                    end
                end
                default: ;
            endcase
        end
    end

    assign rBus = r_rbus;
    assign sat  = r_sat;

endmodule
